ex_muldiv_ctrl: RTL and testbench

//  Sequencer for a multi-cycle multiply/divide unit sitting beside the EX-stage ALU.
//  It accepts one M-extension op from EX and stalls IF/ID/EX while the iterative core runs.
//  It returns a result-valid pulse in the cycle the op leaves EX.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_iter_core.sv | 41 ++++
 rtl/ex_muldiv_ctrl.sv | 131 +++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encoding, FSM state codes and operand-class helpers shared by the mul/div sequencer.
package muldiv_pkg;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic div_class(input logic [2:0] o);
        return o[2];
    endfunction

    function automatic logic mul_class(input logic [2:0] o);
        return !o[2];
    endfunction

    function automatic logic signed_a(input logic [2:0] o);
        return o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic signed_b(input logic [2:0] o);
        return o inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction
endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: 2*XLEN accumulator doing one unsigned add-shift (mul) or restoring
// subtract-shift (div) step per enable; after XLEN steps {hi,lo} is the product or {rem,quot}.
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            init,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    logic [XLEN-1:0] m;
    logic [XLEN:0] sum, rem_c, diff;

    assign sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    assign rem_c = {hi, lo[XLEN-1]};
    // diff[XLEN] is the borrow: set when the partial remainder is below the divisor
    assign diff = rem_c - {1'b0, m};

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            m <= '0;
            hi <= '0;
            lo <= '0;
        end else if (init) begin
            m <= opb;
            hi <= '0;
            lo <= opa;
        end else if (step) begin
            if (is_div) begin
                hi <= diff[XLEN] ? rem_c[XLEN-1:0] : diff[XLEN-1:0];
                lo <= {lo[XLEN-2:0], !diff[XLEN]};
            end else begin
                {hi, lo} <= {sum, lo[XLEN-1:1]};
            end
        end
endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: EX-stage M-extension sequencer; stalls IF/ID/EX while the iterative core runs.
// Define MULDIV_RESULT_CACHE_EN to reuse the last completed result for a matching operand tuple.
module ex_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0] state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] a_r, b_r, core_hi, core_lo, hi_res, lo_res;
    logic [2:0] op_r;
    logic [2*XLEN-1:0] prod;
    logic neg_q, neg_r, sa, sb, ovf, ovf_r, fast, accept, hit;

    assign sa = a[XLEN-1] & signed_a(op);
    assign sb = b[XLEN-1] & signed_b(op);
    assign ovf = op inside {OP_DIV, OP_REM} && a == MIN_NEG && b == '1;
    assign ovf_r = op_r inside {OP_DIV, OP_REM} && a_r == MIN_NEG && b_r == '1;
    assign fast = b == '0 || ovf;
    assign accept = state == S_IDLE && start && !flush;
    assign stall = accept || (state == S_BUSY && !flush);
    assign result_valid = state == S_DONE && !flush;
    assign result = result_valid ? (op_r inside {OP_MUL, OP_DIV, OP_DIVU} ? lo_res : hi_res) : '0;

`ifdef MULDIV_RESULT_CACHE_EN
    logic c_vld, c_div, hit_r;
    logic [1:0] c_sgn;
    logic [XLEN-1:0] c_a, c_b, c_hi, c_lo;

    assign hit = c_vld && c_a == a && c_b == b && c_div == div_class(op)
              && c_sgn == {signed_a(op), signed_b(op)};

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            c_vld <= 1'b0;
            c_div <= 1'b0;
            hit_r <= 1'b0;
            c_sgn <= '0;
            c_a <= '0;
            c_b <= '0;
            c_hi <= '0;
            c_lo <= '0;
        end else begin
            if (accept)
                hit_r <= hit;
            if (flush && state == S_BUSY)
                c_vld <= 1'b0;
            else if (result_valid) begin
                c_vld <= 1'b1;
                c_a <= a_r;
                c_b <= b_r;
                c_div <= div_class(op_r);
                c_sgn <= {signed_a(op_r), signed_b(op_r)};
                c_hi <= hi_res;
                c_lo <= lo_res;
            end
        end
`else
    assign hit = 1'b0;
`endif

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk   (clk),
        .rstn  (rstn),
        .init  (accept && !fast && !hit),
        .step  (state == S_BUSY),
        .is_div(div_class(op_r)),
        .opa   (sa ? -a : a),
        .opb   (sb ? -b : b),
        .hi    (core_hi),
        .lo    (core_lo)
    );

    assign prod = neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};

    // Fast-path results are rebuilt from the latched raw operands; the core never ran for them
    always_comb begin
        hi_res = mul_class(op_r) ? (b_r == '0 ? '0 : prod[2*XLEN-1:XLEN])
               : b_r == '0 ? a_r : ovf_r ? '0 : neg_r ? -core_hi : core_hi;
        lo_res = mul_class(op_r) ? (b_r == '0 ? '0 : prod[XLEN-1:0])
               : b_r == '0 ? '1 : ovf_r ? a_r : neg_q ? -core_lo : core_lo;
`ifdef MULDIV_RESULT_CACHE_EN
        if (hit_r) begin
            hi_res = c_hi;
            lo_res = c_lo;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state <= S_IDLE;
            cnt <= '0;
            a_r <= '0;
            b_r <= '0;
            op_r <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt <= '0;
        end else if (accept) begin
            state <= (fast || hit) ? S_DONE : S_BUSY;
            cnt <= (fast || hit) ? '0 : CNT_W'(XLEN);
            a_r <= a;
            b_r <= b;
            op_r <= op;
            neg_q <= sa ^ sb;
            neg_r <= sa;
        end else if (state == S_BUSY) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1))
                state <= S_DONE;
        end else if (state == S_DONE) begin
            state <= S_IDLE;
        end
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl: scoreboard bench; a driver pushes expected result/stall-length pairs from an
// arithmetic reference model and a negedge monitor pops and compares on every result_valid.
module tb_ex_muldiv_ctrl;
    localparam int XLEN = 32;

    logic clk = 1'b0, rstn = 1'b0, start = 1'b0, flush = 1'b0;
    logic [2:0] op = '0;
    logic [31:0] a = '0, b = '0;
    logic stall, result_valid;
    logic [31:0] result;

    int checks = 0, errors = 0;
    int stall_cnt = 0;
    logic [31:0] px = '0, py = '0;

    typedef struct {
        logic [31:0] res;
        int lat;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

`ifdef MULDIV_RESULT_CACHE_EN
    bit c_vld = 0;
    logic [31:0] c_a, c_b;
    logic [2:0] c_key;
`endif

    ex_muldiv_ctrl #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .stall       (stall),
        .result      (result),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        int qx, qy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        qx = $signed(x);
        qy = $signed(y);
        case (o)
            3'd0, 3'd1: p = sx * sy;
            3'd2: p = sx * uy;
            3'd3: p = ux * uy;
            default: p = '0;
        endcase
        if (o == 3'd0) return p[31:0];
        if (o < 3'd4) return p[63:32];
        if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : x;
        if (o == 3'd4) return qx / qy;
        if (o == 3'd5) return x / y;
        if (o == 3'd6) return qx % qy;
        return x % y;
    endfunction

    function automatic bit is_fast(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        return y == 0 || ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction

    // {divide class, a is signed, b is signed}
    function automatic logic [2:0] op_key(input logic [2:0] o);
        return {o[2], o inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6}, o inside {3'd0, 3'd1, 3'd4, 3'd6}};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 20));
            5: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        bit hit, done;
        hit = 0;
`ifdef MULDIV_RESULT_CACHE_EN
        hit = c_vld && c_a == x && c_b == y && c_key == op_key(o);
        c_vld = 1;
        c_a = x;
        c_b = y;
        c_key = op_key(o);
`endif
        e.res = ref_model(o, x, y);
        e.lat = (is_fast(o, x, y) || hit) ? 1 : XLEN + 1;
        @(posedge clk);
        #1;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        sbq.push_back(e);
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = result_valid;
            if (i == 1) begin
                a = $urandom;
                b = $urandom;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: op %0d got no result_valid, expected one within 100 cycles", o);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rstn || flush)
            stall_cnt = 0;
        else begin
            if (stall)
                stall_cnt++;
            if (result_valid) begin
                if (sbq.size() == 0)
                    chk("unexpected_valid", 32'd1, 32'd0);
                else begin
                    mon_e = sbq.pop_front();
                    chk("result", result, mon_e.res);
                    chk("stall_cycles", stall_cnt, mon_e.lat);
                end
                stall_cnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        chk("reset_stall", 32'(stall), 0);
        chk("reset_valid", 32'(result_valid), 0);
        chk("reset_result", result, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd5, 32'd12345, 32'd0);
        run_op(3'd7, 32'd5, 32'd0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // flush in the 10th BUSY cycle
        @(posedge clk);
        #1;
        start = 1'b1;
        op = 3'd4;
        a = 32'd1000;
        b = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("flush_stall", 32'(stall), 0);
        chk("flush_valid", 32'(result_valid), 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
`ifdef MULDIV_RESULT_CACHE_EN
        c_vld = 0;
`endif
        @(negedge clk);
        chk("post_flush_stall", 32'(stall), 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        chk("no_valid_after_flush", seen, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // reset in the middle of BUSY
        @(posedge clk);
        #1;
        start = 1'b1;
        op = 3'd0;
        a = 32'd99;
        b = 32'd77;
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(stall), 0);
        chk("rst_mid_valid", 32'(result_valid), 0);
        chk("rst_mid_result", result, 0);
`ifdef MULDIV_RESULT_CACHE_EN
        c_vld = 0;
`endif
        @(posedge clk);
        #1;
        rstn = 1'b1;
        run_op(3'd4, 32'd100, 32'd7);
        run_op(3'd6, 32'd100, 32'd7);

        for (int n = 0; n < 60; n++) begin
            if (n == 0 || $urandom_range(0, 3) != 0) begin
                px = pick();
                py = pick();
            end
            run_op(3'($urandom_range(0, 7)), px, py);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
